// File: rtl/bcd_scan_display.sv
// Display consumer: 16-bit binary -> 4 BCD digits via serial double-dabble (17-cycle load/busy
// handshake), time-multiplexed onto a common-anode 4-digit 7-segment display.
module bcd_scan_display #(
   parameter int REFRESH_DIV = 50000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic        load,
   output logic        busy,
   output logic [6:0]  seg7,
   output logic [3:0]  select
);
   localparam int            PW       = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [6:0]    SEG_DASH  = 7'b0111111;
   localparam logic [6:0]    SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   state_t      state_q, state_d;
   logic [15:0] bin_q, bin_d;
   logic [15:0] bcd_q, bcd_d;
   logic [15:0] bcd_adj;
   logic [3:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic [15:0] disp_q, disp_d;
   logic        disp_ovf_q, disp_ovf_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [1:0]  idx_q, idx_d;
   logic [3:0]  dig;
   logic        blank;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         disp_q     <= '0;
         disp_ovf_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         disp_q     <= disp_d;
         disp_ovf_q <= disp_ovf_d;
      end
   end

   // Add-3 correction on every scratch nibble before the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < 4; k++) begin
         if (bcd_q[k*4 +: 4] >= 4'd5)
            bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      disp_d     = disp_q;
      disp_ovf_d = disp_ovf_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = CONVERT;
               bin_d   = value;
               bcd_d   = '0;
               cnt_d   = '0;
               ovf_d   = (value > 16'd9999);
            end
         end
         CONVERT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q + 4'd1;
            if (cnt_q == 4'd15)
               state_d = COMMIT;
         end
         COMMIT: begin
            disp_d     = bcd_q;
            disp_ovf_d = ovf_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   // Scanner runs free of the converter so a display update never disturbs the dwell.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q <= '0;
         idx_q <= '0;
      end else begin
         pre_q <= pre_d;
         idx_q <= idx_d;
      end
   end

   always_comb begin
      pre_d = pre_q + 1'b1;
      idx_d = idx_q;
      if (pre_q == PRE_LAST) begin
         pre_d = '0;
         idx_d = idx_q + 2'd1;
      end
   end

   assign select = ~(4'b0001 << idx_q);

   always_comb begin
      dig = disp_q[{idx_q, 2'b00} +: 4];
      case (idx_q)
         2'd3:    blank = (disp_q[15:12] == 4'd0);
         2'd2:    blank = (disp_q[15:8]  == 8'd0);
         2'd1:    blank = (disp_q[15:4]  == 12'd0);
         default: blank = 1'b0;
      endcase
      if (!BLANK_LZ)
         blank = 1'b0;

      seg7 = SEG_BLANK;
      if (disp_ovf_q) begin
         seg7 = SEG_DASH;
      end else if (!blank) begin
         case (dig)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
         endcase
      end
   end

endmodule
